// File: rtl/dct_coeff_accum_if.sv
// Pixel-in / LUT / coefficient-out bus for one DCT coefficient accumulator.
// slave = accumulator side, master = source/LUT/collector side.
interface dct_coeff_accum_if #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16
);
    logic signed [PIX_W-1:0]  pix_in;
    logic                     pix_valid;
    logic                     pix_first;
    logic                     pix_ready;
    logic        [2:0]        n1;
    logic        [2:0]        n2;
    logic signed [31:0]       cos_term;
    logic signed [COEF_W-1:0] coef_out;
    logic                     coef_valid;
    logic                     coef_ready;

    modport slave (
        input  pix_in, pix_valid, pix_first, cos_term, coef_ready,
        output pix_ready, n1, n2, coef_out, coef_valid
    );

    modport master (
        output pix_in, pix_valid, pix_first, cos_term, coef_ready,
        input  pix_ready, n1, n2, coef_out, coef_valid
    );
endinterface

// File: rtl/dct_coeff_accum.sv
// Multiply-accumulates one 8x8 block against a per-coefficient cosine LUT and
// emits one scaled coefficient per block. Define DCT_ROUND_EN for round-half-up output.
module dct_coeff_accum #(
    parameter int PIX_W     = 8,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8,
    parameter int COEF_W    = 16
) (
    input logic               i_clk,
    input logic               i_reset,
    dct_coeff_accum_if.slave  s_bus
);
    typedef enum logic {ST_ACCUM = 1'b0, ST_OUT = 1'b1} state_t;

    state_t                    r_state;
    logic        [5:0]         r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [COEF_W-1:0]  r_coef;
    logic                      r_coef_valid;
    logic                      r_pix_ready;

    logic                      w_accept;
    logic                      w_resync;
    logic signed [ACC_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]   w_acc_base;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_acc_scaled;
    logic signed [COEF_W-1:0]  w_coef;

    assign w_accept = s_bus.pix_valid && r_pix_ready;
    assign w_resync = s_bus.pix_valid && s_bus.pix_first;

    // A resyncing pixel is element (0,0), so the LUT must see (0,0) this cycle.
    assign s_bus.n1 = w_resync ? 3'd0 : r_idx[5:3];
    assign s_bus.n2 = w_resync ? 3'd0 : r_idx[2:0];

    // Operands widen to ACC_W with sign extension; the result wraps at ACC_W.
    assign w_prod     = s_bus.pix_in * s_bus.cos_term;
    assign w_acc_base = s_bus.pix_first ? '0 : r_acc;
    assign w_acc_next = w_acc_base + w_prod;

`ifdef DCT_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(2 ** (FRAC_BITS - 1));
    assign w_acc_scaled = (w_acc_next + ROUND_K) >>> FRAC_BITS;
`else
    assign w_acc_scaled = w_acc_next >>> FRAC_BITS;
`endif
    assign w_coef = COEF_W'(w_acc_scaled);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_ACCUM;
            r_idx        <= '0;
            r_acc        <= '0;
            r_coef       <= '0;
            r_coef_valid <= 1'b0;
            r_pix_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (s_bus.pix_first) begin
                            r_acc <= w_prod;
                            r_idx <= 6'd1;
                        end else if (r_idx == 6'd63) begin
                            r_coef       <= w_coef;
                            r_coef_valid <= 1'b1;
                            r_pix_ready  <= 1'b0;
                            r_state      <= ST_OUT;
                            r_idx        <= '0;
                            r_acc        <= '0;
                        end else begin
                            r_acc <= w_acc_next;
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (s_bus.coef_ready) begin
                        r_coef_valid <= 1'b0;
                        r_pix_ready  <= 1'b1;
                        r_state      <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_pix_ready <= 1'b1;
                end
            endcase
        end
    end

    assign s_bus.pix_ready  = r_pix_ready;
    assign s_bus.coef_out   = r_coef;
    assign s_bus.coef_valid = r_coef_valid;
endmodule

// File: tb/tb_dct_coeff_accum.sv
// Directed bench for dct_coeff_accum: impulse, constant, backpressure, resync and reset cases.
module tb_dct_coeff_accum;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int   pix_buf [128];
    int   lut_sel;
    int   cap_at;
    logic [2:0] cap_n1;
    logic [2:0] cap_n2;
    bit   pre_valid;

`ifdef DCT_ROUND_EN
    localparam int EXP_P3   = 14;
    localparam int EXP_NEG  = -88;
    localparam int EXP_MIX  = 10;
`else
    localparam int EXP_P3   = 13;
    localparam int EXP_NEG  = -89;
    localparam int EXP_MIX  = 9;
`endif

    dct_coeff_accum_if bus ();

    dct_coeff_accum dut (
        .i_clk   (clk),
        .i_reset (reset),
        .s_bus   (bus)
    );

    // LUT 0: impulse-friendly table; LUT 1: (k1=4,k2=1)-shaped rows that each sum to zero.
    function automatic logic signed [31:0] lut(input int sel, input logic [2:0] r, input logic [2:0] c);
        int idx;
        int rs;
        int cv;
        idx = {26'd0, r, c};
        if (sel == 1) begin
            case (r)
                3'd0, 3'd3, 3'd4, 3'd7: rs = 1;
                default:                rs = -1;
            endcase
            case (c)
                3'd0: cv = 44;   3'd1: cv = 37;   3'd2: cv = 25;   3'd3: cv = 9;
                3'd4: cv = -9;   3'd5: cv = -25;  3'd6: cv = -37;  default: cv = -44;
            endcase
            return 32'(rs * cv);
        end
        if (idx == 0) return 32'sd177;
        if (idx == 3) return 32'sd35;
        return 32'(idx + 1);
    endfunction

    assign bus.cos_term = lut(lut_sel, bus.n1, bus.n2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_buf();
        for (int i = 0; i < 128; i++) pix_buf[i] = 0;
    endtask

    task automatic drive_pixels(input int n, input int first_at);
        pre_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.coef_valid) pre_valid = 1'b1;
            bus.pix_valid = 1'b1;
            bus.pix_in    = 8'(pix_buf[i]);
            bus.pix_first = (i == first_at);
            #1;
            if (i == cap_at) begin
                cap_n1 = bus.n1;
                cap_n2 = bus.n2;
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_first = 1'b0;
        bus.pix_in    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.coef_valid !== 1'b0 || bus.coef_out !== 16'sd0 || bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%0d ready=%b, want 0/0/1",
                     bus.coef_valid, bus.coef_out, bus.pix_ready);
        end
        checks++;
        if (bus.n1 !== 3'd0 || bus.n2 !== 3'd0) begin
            errors++;
            $display("FAIL reset_idx: n1=%0d n2=%0d, want 0/0", bus.n1, bus.n2);
        end
    endtask

    task automatic test_zero_block();
        clear_buf();
        lut_sel = 0;
        cap_at  = 42;
        drive_pixels(64, -1);
        checks++;
        if (pre_valid !== 1'b0 || bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd0 || bus.pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_block: early=%b valid=%b out=%0d ready=%b, want 0/1/0/0",
                     pre_valid, bus.coef_valid, bus.coef_out, bus.pix_ready);
        end
        checks++;
        if (cap_n1 !== 3'd5 || cap_n2 !== 3'd2) begin
            errors++;
            $display("FAIL raster_idx42: n1=%0d n2=%0d, want 5/2", cap_n1, cap_n2);
        end
        @(negedge clk);
        checks++;
        if (bus.coef_valid !== 1'b0 || bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_block_release: valid=%b ready=%b, want 0/1", bus.coef_valid, bus.pix_ready);
        end
    endtask

    task automatic test_constant();
        for (int i = 0; i < 64; i++) pix_buf[i] = 50;
        lut_sel = 1;
        cap_at  = -1;
        drive_pixels(64, 0);
        checks++;
        if (bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd0) begin
            errors++;
            $display("FAIL constant_block: valid=%b out=%0d, want 1/0", bus.coef_valid, bus.coef_out);
        end
        lut_sel = 0;
    endtask

    task automatic test_impulse();
        clear_buf();
        pix_buf[0] = 100;
        cap_at = 11;
        drive_pixels(64, 0);
        checks++;
        if (bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd69) begin
            errors++;
            $display("FAIL impulse_00: valid=%b out=%0d, want 1/69", bus.coef_valid, bus.coef_out);
        end
        checks++;
        if (cap_n1 !== 3'd1 || cap_n2 !== 3'd3) begin
            errors++;
            $display("FAIL raster_idx11: n1=%0d n2=%0d, want 1/3", cap_n1, cap_n2);
        end
        cap_at = -1;

        clear_buf();
        pix_buf[3] = 100;
        drive_pixels(64, 0);
        checks++;
        if (bus.coef_out !== 16'(EXP_P3)) begin
            errors++;
            $display("FAIL impulse_03: out=%0d, want %0d", bus.coef_out, EXP_P3);
        end

        clear_buf();
        pix_buf[0] = -128;
        drive_pixels(64, 0);
        checks++;
        if (bus.coef_out !== 16'(EXP_NEG)) begin
            errors++;
            $display("FAIL impulse_neg: out=%0d, want %0d", bus.coef_out, EXP_NEG);
        end

        clear_buf();
        pix_buf[0] = 10;
        pix_buf[3] = 20;
        drive_pixels(64, 0);
        checks++;
        if (bus.coef_out !== 16'(EXP_MIX)) begin
            errors++;
            $display("FAIL mixed_block: out=%0d, want %0d", bus.coef_out, EXP_MIX);
        end

        // -1 everywhere against LUT 0 sums to -2287
        for (int i = 0; i < 64; i++) pix_buf[i] = -1;
        drive_pixels(64, 0);
        checks++;
        if (bus.coef_out !== -16'sd9) begin
            errors++;
            $display("FAIL all_neg_one: out=%0d, want -9", bus.coef_out);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit bad;
        clear_buf();
        pix_buf[0] = 100;
        bus.coef_ready = 1'b0;
        drive_pixels(64, 0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd69 || bus.pix_ready !== 1'b0) bad = 1'b1;
            bus.pix_valid = 1'b1;
            bus.pix_first = 1'b1;
            bus.pix_in    = 8'sd100;
            @(negedge clk);
        end
        checks++;
        if (bad || bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd69) begin
            errors++;
            $display("FAIL backpressure_hold: valid=%b out=%0d ready=%b, want 1/69/0",
                     bus.coef_valid, bus.coef_out, bus.pix_ready);
        end
        bus.pix_valid  = 1'b0;
        bus.pix_first  = 1'b0;
        bus.pix_in     = '0;
        bus.coef_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.coef_valid !== 1'b0 || bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b ready=%b, want 0/1", bus.coef_valid, bus.pix_ready);
        end
        // Any pixel swallowed during OUT would skew this block's timing and value.
        clear_buf();
        drive_pixels(64, -1);
        checks++;
        if (pre_valid !== 1'b0 || bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd0) begin
            errors++;
            $display("FAIL backpressure_no_accept: early=%b valid=%b out=%0d, want 0/1/0",
                     pre_valid, bus.coef_valid, bus.coef_out);
        end
        @(negedge clk);
    endtask

    task automatic test_resync();
        clear_buf();
        for (int i = 0; i < 20; i++) pix_buf[i] = 7;
        pix_buf[20] = 100;
        cap_at = 20;
        drive_pixels(84, 20);
        checks++;
        if (cap_n1 !== 3'd0 || cap_n2 !== 3'd0) begin
            errors++;
            $display("FAIL resync_n1n2: n1=%0d n2=%0d, want 0/0", cap_n1, cap_n2);
        end
        checks++;
        if (pre_valid !== 1'b0 || bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd69) begin
            errors++;
            $display("FAIL resync_coef: early=%b valid=%b out=%0d, want 0/1/69",
                     pre_valid, bus.coef_valid, bus.coef_out);
        end
        cap_at = -1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) pix_buf[i] = 90;
        drive_pixels(30, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.coef_valid !== 1'b0 || bus.pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_state: valid=%b ready=%b, want 0/1", bus.coef_valid, bus.pix_ready);
        end
        clear_buf();
        pix_buf[0] = 100;
        drive_pixels(64, -1);
        checks++;
        if (pre_valid !== 1'b0 || bus.coef_valid !== 1'b1 || bus.coef_out !== 16'sd69) begin
            errors++;
            $display("FAIL reset_mid_block: early=%b valid=%b out=%0d, want 0/1/69",
                     pre_valid, bus.coef_valid, bus.coef_out);
        end
        @(negedge clk);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        lut_sel        = 0;
        cap_at         = -1;
        cap_n1         = '0;
        cap_n2         = '0;
        pre_valid      = 1'b0;
        reset          = 1'b1;
        bus.pix_in     = '0;
        bus.pix_valid  = 1'b0;
        bus.pix_first  = 1'b0;
        bus.coef_ready = 1'b1;
        test_reset();
        test_zero_block();
        test_constant();
        test_impulse();
        test_backpressure();
        test_resync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
